// File: rtl/mod_pkg.sv
// Shared definitions for the mod_reduce restoring divider.
package mod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Steps per clock must be 1, 2 or 4 and must evenly divide the dividend width.
    function automatic bit steps_legal(input int unsigned steps, input int unsigned dw);
        return ((steps == 1) || (steps == 2) || (steps == 4)) && ((dw % steps) == 0);
    endfunction

endpackage

// File: rtl/mod_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module mod_step #(
    parameter int unsigned SIZE = 64
) (
    input  logic [SIZE:0]   i_acc,
    input  logic [SIZE-1:0] i_divisor,
    input  logic            i_bit,
    output logic [SIZE:0]   o_acc,
    output logic            o_qbit
);

    logic [SIZE:0] w_shift;
    logic [SIZE:0] w_diff;

    assign w_shift = {i_acc[SIZE-1:0], i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    // A set accumulator MSB means the shifted value already exceeds any SIZE-bit divisor.
    assign o_qbit  = i_acc[SIZE] | (w_shift >= {1'b0, i_divisor});
    assign o_acc   = o_qbit ? w_diff : w_shift;

endmodule

// File: rtl/mod_reduce.sv
// Iterative restoring divider: AXI-stream dividend/divisor in, remainder and quotient out.
module mod_reduce
    import mod_pkg::*;
#(
    parameter int unsigned SIZE  = 64,
    parameter int unsigned STEPS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*SIZE-1:0] input_dividen_tdata,
    input  logic              input_dividen_tvalid,
    output logic              input_dividen_tready,
    input  logic [SIZE-1:0]   input_divisor_tdata,
    input  logic              input_divisor_tvalid,
    output logic              input_divisor_tready,
    output logic [SIZE-1:0]   output_tdata,
    output logic [2*SIZE-1:0] output_quot_tdata,
    output logic              output_tuser,
    output logic              output_tvalid,
    input  logic              output_tready
);

    localparam int unsigned DW     = 2 * SIZE;
    localparam int unsigned CYCLES = DW / STEPS;
    localparam int unsigned CW     = $clog2(CYCLES + 1);

    if (!steps_legal(STEPS, DW)) begin : g_bad_steps
        $error("mod_reduce: STEPS must be 1, 2 or 4 and divide 2*SIZE");
    end

    state_t          r_state;
    state_t          w_next;
    logic [SIZE:0]   r_acc;
    logic [DW-1:0]   r_quot;
    logic [SIZE-1:0] r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_tuser;

    logic            w_rdy;
    logic            w_accept;
    logic            w_last;
    logic [SIZE:0]   w_acc [0:STEPS];
    logic [STEPS-1:0] w_qbits;

    assign w_rdy    = rst_n && (r_state == ST_IDLE);
    assign w_accept = w_rdy && input_dividen_tvalid && input_divisor_tvalid;
    assign w_last   = (r_cnt == CW'(CYCLES - 1));

    assign input_dividen_tready = w_rdy;
    assign input_divisor_tready = w_rdy;
    assign output_tvalid        = (r_state == ST_DONE);
    assign output_tdata         = r_acc[SIZE-1:0];
    assign output_quot_tdata    = r_quot;
    assign output_tuser         = r_tuser;

    // r_quot doubles as the dividend shift register: bits leave at the MSB, quotient bits enter at the LSB.
    assign w_acc[0] = r_acc;
    for (genvar g = 0; g < STEPS; g++) begin : g_step
        mod_step #(.SIZE(SIZE)) u_step (
            .i_acc     (w_acc[g]),
            .i_divisor (r_div),
            .i_bit     (r_quot[DW-1-g]),
            .o_acc     (w_acc[g+1]),
            .o_qbit    (w_qbits[STEPS-1-g])
        );
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = (input_divisor_tdata == '0) ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last) w_next = ST_DONE;
            ST_DONE: if (output_tready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_quot  <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_tuser <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_div <= input_divisor_tdata;
                        if (input_divisor_tdata == '0) begin
                            r_quot  <= '1;
                            r_tuser <= 1'b1;
                        end else begin
                            r_quot  <= input_dividen_tdata;
                            r_tuser <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc  <= w_acc[STEPS];
                    r_quot <= {r_quot[DW-STEPS-1:0], w_qbits};
                    r_cnt  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce.sv
// Randomized and directed checks of mod_reduce at STEPS=1 and STEPS=4 against plain arithmetic.
module tb_mod_reduce;

    logic        clk;
    logic        rst_n;
    logic [15:0] a_tdata;
    logic        a_tvalid;
    logic [7:0]  b_tdata;
    logic        b_tvalid;
    logic        o_tready;

    logic        a_rdy1, b_rdy1, u1, v1;
    logic [7:0]  r1;
    logic [15:0] q1;
    logic        a_rdy4, b_rdy4, u4, v4;
    logic [7:0]  r4;
    logic [15:0] q4;

    int n_checks = 0;
    int n_fail   = 0;

    mod_reduce #(.SIZE(8), .STEPS(1)) u_dut1 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .input_dividen_tdata  (a_tdata),
        .input_dividen_tvalid (a_tvalid),
        .input_dividen_tready (a_rdy1),
        .input_divisor_tdata  (b_tdata),
        .input_divisor_tvalid (b_tvalid),
        .input_divisor_tready (b_rdy1),
        .output_tdata         (r1),
        .output_quot_tdata    (q1),
        .output_tuser         (u1),
        .output_tvalid        (v1),
        .output_tready        (o_tready)
    );

    mod_reduce #(.SIZE(8), .STEPS(4)) u_dut4 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .input_dividen_tdata  (a_tdata),
        .input_dividen_tvalid (a_tvalid),
        .input_dividen_tready (a_rdy4),
        .input_divisor_tdata  (b_tdata),
        .input_divisor_tvalid (b_tvalid),
        .input_divisor_tready (b_rdy4),
        .output_tdata         (r4),
        .output_quot_tdata    (q4),
        .output_tuser         (u4),
        .output_tvalid        (v4),
        .output_tready        (o_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction on both instances; hold = extra cycles with output_tready low in DONE.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        eu;
        int n, lat1, lat4, guard;
        if (b == 8'd0) begin
            eq = 16'hFFFF; er = 8'd0; eu = 1'b1;
        end else begin
            eq = a / b;    er = 8'(a % b); eu = 1'b0;
        end
        guard = 0;
        while (!(a_rdy1 && a_rdy4) && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        check_eq("ready_before_op", {a_rdy1, b_rdy1, a_rdy4, b_rdy4}, 4'hF);
        @(negedge clk);
        a_tdata = a; b_tdata = b; a_tvalid = 1'b1; b_tvalid = 1'b1;
        @(posedge clk); #1;
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        check_eq("busy_after_accept", {a_rdy1, b_rdy1, a_rdy4, b_rdy4}, 4'h0);
        n = 1; lat1 = 0; lat4 = 0;
        forever begin
            if (v1 && lat1 == 0) lat1 = n;
            if (v4 && lat4 == 0) lat4 = n;
            if ((lat1 != 0 && lat4 != 0) || n >= 100) break;
            @(posedge clk); #1; n++;
        end
        check_eq("latency_s1", lat1, (b == 8'd0) ? 1 : 17);
        check_eq("latency_s4", lat4, (b == 8'd0) ? 1 : 5);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_s1", {r1, q1, u1, v1, a_rdy1, b_rdy1}, {er, eq, eu, 3'b100});
            check_eq("hold_s4", {r4, q4, u4, v4, a_rdy4, b_rdy4}, {er, eq, eu, 3'b100});
        end
        check_eq("rem_s1",  r1, er);
        check_eq("quot_s1", q1, eq);
        check_eq("user_s1", u1, eu);
        check_eq("rem_s4",  r4, er);
        check_eq("quot_s4", q4, eq);
        check_eq("user_s4", u4, eu);
        @(negedge clk);
        o_tready = 1'b1;
        @(posedge clk); #1;
        check_eq("after_handshake", {v1, v4, a_rdy1, a_rdy4}, 4'b0011);
        o_tready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; a_tdata = '0; b_tdata = '0; a_tvalid = 1'b0; b_tvalid = 1'b0; o_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_s1", {r1, q1, u1, v1, a_rdy1, b_rdy1}, 28'h0);
        check_eq("reset_s4", {r4, q4, u4, v4, a_rdy4, b_rdy4}, 28'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_reset", {a_rdy1, b_rdy1, a_rdy4, b_rdy4}, 4'hF);

        run_op(16'h1234, 8'h07, 0);
        run_op(16'hFFFF, 8'hFF, 0);
        run_op(16'h0005, 8'h09, 0);
        run_op(16'h0005, 8'h00, 0);

        // Only one operand valid: nothing may be consumed.
        @(negedge clk);
        a_tdata = 16'hBEEF; a_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("dividend_only", {a_rdy1, a_rdy4, v1, v4}, 4'b1100);
        end
        @(negedge clk);
        a_tvalid = 1'b0; b_tdata = 8'h3C; b_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("divisor_only", {b_rdy1, b_rdy4, v1, v4}, 4'b1100);
        end
        b_tvalid = 1'b0;
        run_op(16'hBEEF, 8'h3C, 0);

        run_op(16'hA5C3, 8'h11, 20);

        // Reset during CALC aborts the operation.
        @(negedge clk);
        a_tdata = 16'h1234; b_tdata = 8'h07; a_tvalid = 1'b1; b_tvalid = 1'b1;
        @(posedge clk); #1;
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("in_reset", {a_rdy1, b_rdy1, a_rdy4, b_rdy4, v1, v4}, 6'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_abort", {a_rdy1, b_rdy1, a_rdy4, b_rdy4}, 4'hF);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            check_eq("no_result_after_abort", {v1, v4}, 2'b00);
        end
        run_op(16'h00FF, 8'h01, 0);

        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra;
            logic [7:0]  rb;
            ra = 16'($urandom);
            case ($urandom_range(0, 4))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                2:       rb = 8'($urandom_range(1, 3));
                default: rb = 8'($urandom);
            endcase
            run_op(ra, rb, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
